// File: rtl/pe2_wb_align_if.sv
// Coefficient-RAM writeback bus between pe2_wb_align and the RAM port.
// An entry moves when wr_en and wr_ready are both high.
interface pe2_wb_align_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
);
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr_a;
  logic [DATA_WIDTH-1:0] wr_data_a;
  logic [ADDR_WIDTH-1:0] wr_addr_b;
  logic [DATA_WIDTH-1:0] wr_data_b;

  modport master (
    output wr_en, wr_addr_a, wr_data_a, wr_addr_b, wr_data_b,
    input  wr_ready
  );

  modport slave (
    input  wr_en, wr_addr_a, wr_data_a, wr_addr_b, wr_data_b,
    output wr_ready
  );
endinterface

// File: rtl/pe2_wb_align.sv
// PE2 writeback aligner: tag pipeline matched to butterfly latency, FWFT write FIFO, layer pulse.
// Optional operand range check enabled by defining WB_RANGE_CHECK_EN.
module pe2_wb_align #(
  parameter int DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 8,
  parameter int LAT_NTT      = 9,
  parameter int LAT_INTT     = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int BF_PER_LAYER = 128,
  parameter int Q            = 3329
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_sel,
  input  logic [ADDR_WIDTH-1:0] issue_addr_u,
  input  logic [ADDR_WIDTH-1:0] issue_addr_v,
  input  logic [DATA_WIDTH-1:0] bf_lower,
  input  logic [DATA_WIDTH-1:0] bf_upper,
  pe2_wb_align_if.master        wr,
  output logic                  layer_done,
  output logic                  busy,
  output logic                  overflow,
  output logic                  mode_err,
  output logic                  range_err
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W  = (BF_PER_LAYER > 1) ? $clog2(BF_PER_LAYER) : 1;

  typedef struct packed {
    logic                  valid;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] addr_u;
    logic [ADDR_WIDTH-1:0] addr_v;
  } tag_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_b;
  } wb_entry_t;

  // pipe[k-1] holds the tag issued k cycles ago
  tag_t pipe [LAT_INTT];

  logic      tap_ntt, tap_intt, capture;
  wb_entry_t cap_entry;

  assign tap_ntt  = pipe[LAT_NTT-1].valid  & ~pipe[LAT_NTT-1].sel;
  assign tap_intt = pipe[LAT_INTT-1].valid &  pipe[LAT_INTT-1].sel;
  assign capture  = tap_ntt | tap_intt;

  // On a collision the NTT tag wins and the INTT result is lost
  assign cap_entry = tap_ntt ?
    '{addr_a: pipe[LAT_NTT-1].addr_u,  data_a: bf_lower,
      addr_b: pipe[LAT_NTT-1].addr_v,  data_b: bf_upper} :
    '{addr_a: pipe[LAT_INTT-1].addr_u, data_a: bf_lower,
      addr_b: pipe[LAT_INTT-1].addr_v, data_b: bf_upper};

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT_INTT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: issue_valid, sel: issue_sel,
                   addr_u: issue_addr_u, addr_v: issue_addr_v};
      for (int i = 1; i < LAT_INTT; i++) begin
        pipe[i] <= pipe[i-1];
        if (i == LAT_NTT) pipe[i].valid <= pipe[i-1].valid & ~tap_ntt;
      end
    end
  end

  wb_entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]     fifo_cnt;
  logic                  full, push, pop;
  wb_entry_t             head;

  assign full = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
  assign pop  = wr.wr_en & wr.wr_ready;
  assign push = capture & (~full | pop);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage is tiny and drives outputs directly, so it is reset to keep outputs at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cap_entry;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (capture && full && !pop) overflow <= 1'b1;
    end
  end

  assign head         = mem[rd_ptr];
  assign wr.wr_en     = (fifo_cnt != '0);
  assign wr.wr_addr_a = head.addr_a;
  assign wr.wr_data_a = head.data_a;
  assign wr.wr_addr_b = head.addr_b;
  assign wr.wr_data_b = head.data_b;

  logic [CNT_W-1:0] layer_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_cnt  <= '0;
      layer_done <= 1'b0;
      mode_err   <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      if (pop) begin
        if (layer_cnt == CNT_W'(BF_PER_LAYER - 1)) begin
          layer_cnt  <= '0;
          layer_done <= 1'b1;
        end else begin
          layer_cnt <= layer_cnt + 1'b1;
        end
      end
      if (tap_ntt && tap_intt) mode_err <= 1'b1;
    end
  end

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    busy = wr.wr_en;
    for (int i = 0; i < LAT_INTT; i++) busy = busy | pipe[i].valid;
  end

`ifdef WB_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if (capture && (int'(cap_entry.data_a) >= Q || int'(cap_entry.data_b) >= Q)) begin
      range_err <= 1'b1;
    end
  end
`else
  logic [31:0] unused_q;
  assign unused_q  = 32'(Q);
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_pe2_wb_align.sv
// Directed self-checking bench for pe2_wb_align; cycle n is the interval after the n-th clock
// edge following each reset, with inputs driven and outputs sampled 1 ns after the edge.
module tb_pe2_wb_align;
  localparam int AW = 8;
  localparam int DW = 12;

`ifdef WB_RANGE_CHECK_EN
  localparam logic RANGE_EXP = 1'b1;
`else
  localparam logic RANGE_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid, issue_sel;
  logic [AW-1:0] issue_addr_u, issue_addr_v;
  logic [DW-1:0] bf_lower, bf_upper;
  logic          layer_done, busy, overflow, mode_err, range_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe2_wb_align_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  pe2_wb_align #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAT_NTT(9), .LAT_INTT(16),
    .FIFO_DEPTH(4), .BF_PER_LAYER(128), .Q(3329)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_sel    (issue_sel),
    .issue_addr_u (issue_addr_u),
    .issue_addr_v (issue_addr_v),
    .bf_lower     (bf_lower),
    .bf_upper     (bf_upper),
    .wr           (wb),
    .layer_done   (layer_done),
    .busy         (busy),
    .overflow     (overflow),
    .mode_err     (mode_err),
    .range_err    (range_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ent(input logic [AW-1:0] a, input logic [DW-1:0] da,
                                      input logic [AW-1:0] b, input logic [DW-1:0] db);
    return {24'd0, a, da, b, db};
  endfunction

  function automatic logic [63:0] head();
    return {24'd0, wb.wr_addr_a, wb.wr_data_a, wb.wr_addr_b, wb.wr_data_b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_sel    = 1'b0;
    issue_addr_u = '0;
    issue_addr_v = '0;
    bf_lower     = 12'h5A5;
    bf_upper     = 12'h3C3;
  endtask

  task automatic issue(input logic sel, input logic [AW-1:0] u, input logic [AW-1:0] v);
    issue_valid  = 1'b1;
    issue_sel    = sel;
    issue_addr_u = u;
    issue_addr_v = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    wb.wr_ready = 1'b1;
    #1;
    check("rst_status", 64'({layer_done, busy, overflow, mode_err, range_err, wb.wr_en}), 64'd0);
    check("rst_head", head(), 64'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int xfer, ld, ld_cyc, seen;
    rst = 1'b1;
    wb.wr_ready = 1'b0;
    idle();

    // Single NTT butterfly
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      idle();
      if (c == 0) issue(1'b0, 8'h10, 8'h90);
      if (c == 9) begin bf_lower = 12'd123; bf_upper = 12'd456; end
      if (c == 1) check("t1_busy_c1", 64'(busy), 64'd1);
      if (c == 9) check("t1_wr_en_c9", 64'(wb.wr_en), 64'd0);
      if (c == 10) begin
        check("t1_wr_en_c10", 64'(wb.wr_en), 64'd1);
        check("t1_head", head(), ent(8'h10, 12'd123, 8'h90, 12'd456));
      end
      if (c == 11) begin
        check("t1_busy_c11", 64'(busy), 64'd0);
        check("t1_wr_en_c11", 64'(wb.wr_en), 64'd0);
      end
      step();
    end

    // Single INTT butterfly; bf values at the NTT tap must be ignored
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      idle();
      if (c == 0) issue(1'b1, 8'h03, 8'h07);
      if (c == 9)  begin bf_lower = 12'd11;   bf_upper = 12'd22;   end
      if (c == 16) begin bf_lower = 12'd1000; bf_upper = 12'd2000; end
      if (c == 10) check("t2_wr_en_c10", 64'(wb.wr_en), 64'd0);
      if (c == 16) check("t2_wr_en_c16", 64'(wb.wr_en), 64'd0);
      if (c == 17) begin
        check("t2_wr_en_c17", 64'(wb.wr_en), 64'd1);
        check("t2_head", head(), ent(8'h03, 12'd1000, 8'h07, 12'd2000));
      end
      if (c == 18) check("t2_busy_c18", 64'(busy), 64'd0);
      step();
    end

    // Full layer of back-to-back NTT butterflies
    do_reset();
    xfer = 0; ld = 0; ld_cyc = -1;
    for (int c = 0; c <= 145; c++) begin
      idle();
      if (c < 128) issue(1'b0, 8'(c), 8'(c + 128));
      if (c >= 9 && c < 137) begin
        bf_lower = 12'(c - 9);
        bf_upper = 12'(c - 9 + 2000);
      end
      if (wb.wr_en && wb.wr_ready) begin
        check("t3_xfer", head(), ent(8'(xfer), 12'(xfer), 8'(xfer + 128), 12'(xfer + 2000)));
        xfer++;
      end
      if (layer_done) begin ld++; ld_cyc = c; end
      step();
    end
    check("t3_xfer_count", 64'(xfer), 64'd128);
    check("t3_layer_done_pulses", 64'(ld), 64'd1);
    check("t3_layer_done_cycle", 64'(ld_cyc), 64'd138);
    check("t3_layer_cnt", 64'(dut.layer_cnt), 64'd0);
    check("t3_busy_end", 64'(busy), 64'd0);

    // Backpressure: RAM stalls cycles 9..18 while eight results arrive
    do_reset();
    xfer = 0;
    for (int c = 0; c <= 30; c++) begin
      idle();
      if (c < 8) issue(1'b0, 8'(8'h20 + c), 8'(8'hA0 + c));
      if (c >= 9 && c < 17) begin
        bf_lower = 12'(100 + c - 9);
        bf_upper = 12'(200 + c - 9);
      end
      wb.wr_ready = !(c >= 9 && c <= 18);
      if (c == 13) begin
        check("t4_fifo_full", 64'(dut.fifo_cnt), 64'd4);
        check("t4_overflow_c13", 64'(overflow), 64'd0);
      end
      if (c == 14) check("t4_overflow_c14", 64'(overflow), 64'd1);
      if (c >= 10 && c <= 18) check("t4_hold", head(), ent(8'h20, 12'd100, 8'hA0, 12'd200));
      if (wb.wr_en && wb.wr_ready) begin
        check("t4_xfer", head(), ent(8'(8'h20 + xfer), 12'(100 + xfer), 8'(8'hA0 + xfer), 12'(200 + xfer)));
        xfer++;
      end
      step();
    end
    check("t4_xfer_count", 64'(xfer), 64'd4);
    check("t4_overflow_sticky", 64'(overflow), 64'd1);
    check("t4_busy_end", 64'(busy), 64'd0);

    // Mode switch without drain: INTT at cycle 0 and NTT at cycle 7 both tap at cycle 16
    do_reset();
    xfer = 0;
    for (int c = 0; c <= 26; c++) begin
      idle();
      if (c == 0) issue(1'b1, 8'h40, 8'h41);
      if (c == 7) issue(1'b0, 8'h50, 8'h51);
      if (c == 16) begin bf_lower = 12'd7; bf_upper = 12'd8; end
      if (c == 16) check("t5_mode_err_c16", 64'(mode_err), 64'd0);
      if (c == 17) check("t5_mode_err_c17", 64'(mode_err), 64'd1);
      if (wb.wr_en && wb.wr_ready) begin
        check("t5_xfer", head(), ent(8'h50, 12'd7, 8'h51, 12'd8));
        xfer++;
      end
      step();
    end
    check("t5_xfer_count", 64'(xfer), 64'd1);
    check("t5_overflow", 64'(overflow), 64'd0);
    check("t5_range_err", 64'(range_err), 64'd0);

    // Reset while a tag is in flight: nothing may be written afterwards
    do_reset();
    seen = 0;
    for (int c = 0; c <= 20; c++) begin
      idle();
      if (c == 0) issue(1'b0, 8'h33, 8'h44);
      if (c == 3) check("t6_busy_before", 64'(busy), 64'd1);
      if (c == 5) begin
        rst = 1'b1;
        #1;
        check("t6_busy_in_rst", 64'(busy), 64'd0);
      end
      if (c == 7) rst = 1'b0;
      if (wb.wr_en) seen++;
      step();
    end
    check("t6_no_writes", 64'(seen), 64'd0);

    // Range boundary: 3328 is legal, 3329 flags only when the check is built
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      idle();
      if (c == 0) issue(1'b0, 8'h11, 8'h22);
      if (c == 1) issue(1'b0, 8'h12, 8'h23);
      if (c == 9)  begin bf_lower = 12'd3328; bf_upper = 12'd3328; end
      if (c == 10) begin bf_lower = 12'd5;    bf_upper = 12'd3329; end
      if (c == 10) begin
        check("t7_range_err_c10", 64'(range_err), 64'd0);
        check("t7_head0", head(), ent(8'h11, 12'd3328, 8'h22, 12'd3328));
      end
      if (c == 11) begin
        check("t7_range_err_c11", 64'(range_err), 64'(RANGE_EXP));
        check("t7_wr_en_c11", 64'(wb.wr_en), 64'd1);
        check("t7_head1", head(), ent(8'h12, 12'd5, 8'h23, 12'd3329));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
